// File: rtl/camera_power_off_seq.sv
// Camera power-down sequencer: drains capture to a frame boundary, holds RESETB low,
// raises PWDN, removes the supply rail, and re-arms power-up once stop_req is withdrawn.
//
// state | meaning
// IDLE  | camera running; capture_en follows camera_ready
// DRAIN | capture gated; waiting for a clean VSYNC rising edge or the drain timeout
// RST   | RESETB override held low
// PWDN  | PWDN override high, RESETB still low
// OFF   | supply rail removed; waiting for stop_req to drop
module camera_power_off_seq #(
  parameter logic [19:0] T_DRAIN_MAX = 20'hFFFFF,
  parameter logic [15:0] T_RST       = 16'hFFFF,
  parameter logic [17:0] T_PWDN      = 18'h3FFFF
) (
  input  logic clk_50M,
  input  logic reset,
  input  logic stop_req,
  input  logic camera_ready,
  input  logic sccb_busy,
  input  logic cam_vsync,
  output logic capture_en,
  output logic camera_rstn_ovr,
  output logic camera_pwnd_ovr,
  output logic rail_en,
  output logic off_done,
  output logic restart,
  output logic drain_timeout
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_DRAIN = 3'd1,
    S_RST   = 3'd2,
    S_PWDN  = 3'd3,
    S_OFF   = 3'd4
  } state_t;

  localparam logic [19:0] DRAIN_LAST = T_DRAIN_MAX - 20'd1;
  localparam logic [19:0] RST_LAST   = 20'(T_RST) - 20'd1;
  localparam logic [19:0] PWDN_LAST  = 20'(T_PWDN) - 20'd1;

  state_t      state, state_nxt;
  logic [19:0] cnt, cnt_nxt;
  logic        vs_d1, vs_d2, vs_edge;
  logic        capture_nxt, rstn_nxt, pwnd_nxt, rail_nxt, off_nxt, restart_nxt, timeout_nxt;

  // Edge is seen one cycle after VSYNC is first sampled high.
  assign vs_edge = vs_d1 & ~vs_d2;

  always_comb begin
    state_nxt   = state;
    cnt_nxt     = 20'd0;
    capture_nxt = capture_en;
    rstn_nxt    = camera_rstn_ovr;
    pwnd_nxt    = camera_pwnd_ovr;
    rail_nxt    = rail_en;
    off_nxt     = off_done;
    restart_nxt = 1'b0;
    timeout_nxt = drain_timeout;
    case (state)
      S_IDLE: begin
        capture_nxt = camera_ready;
        if (stop_req && camera_ready) begin
          state_nxt   = S_DRAIN;
          capture_nxt = 1'b0;
          timeout_nxt = 1'b0;
        end
      end
      S_DRAIN: begin
        cnt_nxt = cnt + 20'd1;
        // A clean frame boundary takes priority over the timeout in the same cycle.
        if (vs_edge && !sccb_busy) begin
          state_nxt = S_RST;
          cnt_nxt   = 20'd0;
          rstn_nxt  = 1'b0;
        end else if (cnt == DRAIN_LAST) begin
          state_nxt   = S_RST;
          cnt_nxt     = 20'd0;
          rstn_nxt    = 1'b0;
          timeout_nxt = 1'b1;
        end
      end
      S_RST: begin
        cnt_nxt = cnt + 20'd1;
        if (cnt == RST_LAST) begin
          state_nxt = S_PWDN;
          cnt_nxt   = 20'd0;
          pwnd_nxt  = 1'b1;
        end
      end
      S_PWDN: begin
        cnt_nxt = cnt + 20'd1;
        if (cnt == PWDN_LAST) begin
          state_nxt = S_OFF;
          cnt_nxt   = 20'd0;
          rail_nxt  = 1'b0;
          off_nxt   = 1'b1;
        end
      end
      S_OFF: begin
        if (!stop_req) begin
          state_nxt   = S_IDLE;
          rail_nxt    = 1'b1;
          off_nxt     = 1'b0;
          rstn_nxt    = 1'b1;
          pwnd_nxt    = 1'b0;
          restart_nxt = 1'b1;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_50M) begin
    if (reset) begin
      state           <= S_IDLE;
      cnt             <= 20'd0;
      vs_d1           <= 1'b0;
      vs_d2           <= 1'b0;
      capture_en      <= 1'b0;
      camera_rstn_ovr <= 1'b1;
      camera_pwnd_ovr <= 1'b0;
      rail_en         <= 1'b1;
      off_done        <= 1'b0;
      restart         <= 1'b0;
      drain_timeout   <= 1'b0;
    end else begin
      state           <= state_nxt;
      cnt             <= cnt_nxt;
      vs_d1           <= cam_vsync;
      vs_d2           <= vs_d1;
      capture_en      <= capture_nxt;
      camera_rstn_ovr <= rstn_nxt;
      camera_pwnd_ovr <= pwnd_nxt;
      rail_en         <= rail_nxt;
      off_done        <= off_nxt;
      restart         <= restart_nxt;
      drain_timeout   <= timeout_nxt;
    end
  end

endmodule

// File: doc/camera_power_off_seq.md
CAMERA_POWER_OFF_SEQ -- requirements
Module: camera_power_off_seq

Interface
REQ-001 Parameter T_DRAIN_MAX, default 20'hFFFFF, maximum DRAIN wait in clk_50M cycles (~21 ms).
REQ-002 Parameter T_RST, default 16'hFFFF, RESETB-low hold before PWDN rises (~1.3 ms).
REQ-003 Parameter T_PWDN, default 18'h3FFFF, PWDN-high hold before rail removal (~5 ms).
REQ-004 clk_50M  input  1  sole clock, 50 MHz.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 stop_req  input  1  level; high requests camera shutdown, low requests wake.
REQ-007 camera_ready  input  1  level; high once power-up sequencing has completed.
REQ-008 sccb_busy  input  1  level; high while an SCCB register transaction is in flight.
REQ-009 cam_vsync  input  1  camera VSYNC, already synchronous to clk_50M.
REQ-010 capture_en  output  1  gate for the capture/write path.
REQ-011 camera_rstn_ovr  output  1  RESETB override; board RESETB = power-up rstn AND this.
REQ-012 camera_pwnd_ovr  output  1  PWDN override; board PWDN = power-up pwnd OR this.
REQ-013 rail_en  output  1  camera supply rail enable.
REQ-014 off_done  output  1  high while the camera is fully powered down.
REQ-015 restart  output  1  one-cycle pulse that re-arms the power-up sequencer.
REQ-016 drain_timeout  output  1  sticky; drain ended by timeout rather than a frame boundary.

Function
REQ-017 The FSM SHALL have five states: IDLE, DRAIN, RST, PWDN and OFF.
REQ-018 A single 20-bit counter SHALL clear on every state entry and increment each cycle while in DRAIN, RST or PWDN.
REQ-019 IDLE: capture_en SHALL register camera_ready; go to DRAIN when stop_req=1 and camera_ready=1; stop_req with camera_ready=0 is ignored.
REQ-020 On DRAIN entry, capture_en SHALL go 0 on the same edge.
REQ-021 DRAIN SHALL detect a VSYNC rising edge from registered cam_vsync (1-cycle latency).
REQ-022 DRAIN SHALL exit to RST on the first detected edge with sccb_busy=0.
- An edge coinciding with sccb_busy=1 is discarded; the block waits for the next edge.
REQ-023 DRAIN timeout: if counter==T_DRAIN_MAX-1, go to RST and set drain_timeout=1.
- Edge and timeout in the same cycle: edge wins; drain_timeout stays 0.
REQ-024 RST: camera_rstn_ovr=0 from the entry edge; exit to PWDN when counter==T_RST-1, giving exactly T_RST cycles of RESETB low before PWDN.
REQ-025 PWDN: camera_pwnd_ovr=1 from the entry edge, camera_rstn_ovr held 0; exit to OFF when counter==T_PWDN-1.
REQ-026 OFF: rail_en=0 and off_done=1 from the entry edge; camera_rstn_ovr=0 and camera_pwnd_ovr=1 held.
REQ-027 OFF with stop_req=0: on one edge, rail_en=1, off_done=0, camera_rstn_ovr=1, camera_pwnd_ovr=0, restart=1 for exactly that one cycle, next state IDLE.
REQ-028 stop_req deasserting during DRAIN/RST/PWDN SHALL NOT abort the sequence; wake is evaluated only in OFF.
REQ-029 drain_timeout SHALL clear only on reset or on entry to DRAIN.
REQ-030 All outputs SHALL be registered; no combinational input-to-output path.
REQ-031 Parameter values below 2 are unsupported.

Reset
REQ-032 On reset, at the next edge, state=IDLE, counter=0, capture_en=0, camera_rstn_ovr=1, camera_pwnd_ovr=0, rail_en=1, off_done=0, restart=0, drain_timeout=0.
REQ-033 Reset asserted in any state, including mid-count, SHALL take priority and produce the REQ-032 values on the next edge.

Verification (T_DRAIN_MAX=10, T_RST=4, T_PWDN=6)
REQ-034 Nominal shutdown:
- Stimulus: camera_ready=1, then stop_req=1, then a VSYNC edge 3 cycles later with sccb_busy=0.
- Response: capture_en falls on the DRAIN entry edge; rstn_ovr low 4 cycles before pwnd_ovr rises; rail_en falls 6 cycles after pwnd_ovr rises; off_done=1; drain_timeout=0.
REQ-035 No VSYNC:
- Stimulus: stop_req=1 with cam_vsync held 0.
- Response: RST entered 10 cycles after DRAIN entry; drain_timeout=1.
REQ-036 Busy at edge:
- Stimulus: first VSYNC edge with sccb_busy=1, second edge with sccb_busy=0.
- Response: RST entered only after the second edge.
REQ-037 Wake:
- Stimulus: in OFF, drop stop_req.
- Response: restart high exactly 1 cycle; rail_en=1, rstn_ovr=1, pwnd_ovr=0 on that edge; IDLE next.
REQ-038 Reset mid-PWDN:
- Stimulus: assert reset at PWDN counter=3.
- Response: REQ-032 values at the next edge; a subsequent stop_req restarts the sequence from DRAIN.
REQ-039 Not ready:
- Stimulus: stop_req=1 with camera_ready=0 for 20 cycles.
- Response: state remains IDLE; outputs unchanged.
